cpu_step_controller: RTL

Sequencing controller for the single-cycle MIPS core. It consumes the decoded halt/input/output/save/load flags from the control unit and decides each cycle whether the PC advances and whether the current instruction's writeback commits. This stalls the core for user input (switches + enter button) and for the external save/load storage handshake. It also latches the output display register and freezes the core on HALT.

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/rise_detect.sv | 31 +++
 rtl/cpu_step_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the MIPS step controller: FSM states and flag-priority decode.
package cpu_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        StStart    = 3'd0,
        StRun      = 3'd1,
        StWaitIn   = 3'd2,
        StInCommit = 3'd3,
        StMemWait  = 3'd4,
        StHalted   = 3'd5
    } state_e;

    // Decoded action of the current instruction. Encoding doubles as the
    // priority order: a higher value wins when several flags are set
    // (halt > input > save/load > output).
    typedef enum logic [2:0] {
        ActNone   = 3'd0,
        ActOutput = 3'd1,
        ActMem    = 3'd2,
        ActInput  = 3'd3,
        ActHalt   = 3'd4
    } action_e;

    // Collapse the decoded flags into the single highest-priority action.
    function automatic action_e decode_flags(
        input logic halt,
        input logic inp,
        input logic save,
        input logic load,
        input logic outp
    );
        action_e act;
        if (halt) begin
            act = ActHalt;
        end else if (inp) begin
            act = ActInput;
        end else if (save || load) begin
            act = ActMem;
        end else if (outp) begin
            act = ActOutput;
        end else begin
            act = ActNone;
        end
        return act;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; history updates every cycle.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    // Next history is simply the current level.
    always_comb begin
        prev_d = level_i;
    end

    // History flop, cleared on reset so a level held through reset counts as a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Rise when the level is high now and was low at the previous sample.
    always_comb begin
        rise_o = level_i & ~prev_q;
    end

endmodule

// File: rtl/cpu_step_controller.sv
// Step controller for the single-cycle MIPS core: decides PC advance and
// writeback commit per cycle, stalling for user input and storage handshakes.
module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt_flag,
    input  logic                  input_flag,
    input  logic                  output_flag,
    input  logic                  save_flag,
    input  logic                  load_flag,
    input  logic [DATA_WIDTH-1:0] out_data,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  enter_btn,
    input  logic                  mem_ack,
    output logic                  pc_enable,
    output logic                  wb_enable,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] input_value,
    output logic [DATA_WIDTH-1:0] display_value,
    output logic                  waiting_input,
    output logic                  halted
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] input_value_q, input_value_d;
    logic [DATA_WIDTH-1:0] display_value_q, display_value_d;
    logic                  enter_rise;
    action_e               act;

    rise_detect u_enter_rise (
        .clk_i   (clock),
        .rst_ni  (reset),
        .level_i (enter_btn),
        .rise_o  (enter_rise)
    );

    // Priority-resolve the current instruction's flags.
    always_comb begin
        act = decode_flags(halt_flag, input_flag, save_flag, load_flag, output_flag);
    end

    // Next state, data-register updates and the combinational stall decision.
    always_comb begin
        state_d         = state_q;
        input_value_d   = input_value_q;
        display_value_d = display_value_q;
        pc_enable       = 1'b0;
        wb_enable       = 1'b0;
        mem_req         = 1'b0;
        waiting_input   = 1'b0;
        halted          = 1'b0;

        unique case (state_q)
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                unique case (act)
                    ActNone: begin
                        pc_enable = 1'b1;
                        wb_enable = 1'b1;
                    end
                    ActOutput: begin
                        pc_enable       = 1'b1;
                        wb_enable       = 1'b1;
                        display_value_d = out_data;
                    end
                    ActMem: begin
                        mem_req = 1'b1;
                        state_d = StMemWait;
                    end
                    ActInput: begin
                        state_d = StWaitIn;
                    end
                    ActHalt: begin
                        state_d = StHalted;
                    end
                    default: begin
                        state_d = StRun;
                    end
                endcase
            end
            StWaitIn: begin
                waiting_input = 1'b1;
                // Only a fresh press counts; a level held on entry has no rise.
                if (enter_rise) begin
                    input_value_d = sw_data;
                    state_d       = StInCommit;
                end
            end
            StInCommit: begin
                pc_enable = 1'b1;
                wb_enable = 1'b1;
                state_d   = StRun;
            end
            StMemWait: begin
                mem_req = 1'b1;
                // Commit in the ack cycle itself; request drops once back in RUN.
                if (mem_ack) begin
                    pc_enable = 1'b1;
                    wb_enable = 1'b1;
                    state_d   = StRun;
                end
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StStart;
            end
        endcase
    end

    // State and data registers; async reset abandons any pending operation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StStart;
            input_value_q   <= '0;
            display_value_q <= '0;
        end else begin
            state_q         <= state_d;
            input_value_q   <= input_value_d;
            display_value_q <= display_value_d;
        end
    end

    // Registered data outputs.
    always_comb begin
        input_value   = input_value_q;
        display_value = display_value_q;
    end

endmodule
